// File: rtl/la_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : la_scan_sequencer
// Purpose  : Raster scan sequencer. It walks a cols x rows grid, holds each
//            cell for a programmable dwell time, and drives the column, row
//            and power fields of the logic-analyser bus.
// Options  : SCAN_SERPENTINE_EN - odd rows are scanned in descending column
//            order.
// Revision : 1.0 - initial release
// ============================================================================
module la_scan_sequencer #(
    parameter int DWELL_W = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         cfg_cols,
    input  logic [7:0]         cfg_rows,
    input  logic [7:0]         cfg_power,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [7:0]         column_o,
    output logic [7:0]         row_o,
    output logic [7:0]         power_o,
    output logic               cell_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] c_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    // S_DWELL holds the leading cycles of a cell. S_STEP is the last dwell
    // cycle of a cell, where the advance to the next cell happens.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cols;
    logic [7:0]           r_rows;
    logic [7:0]           r_power;
    logic [7:0]           r_col;
    logic [7:0]           r_row;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   r_cnt;

    logic [7:0]           w_col_nxt;
    logic [7:0]           w_row_nxt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic                 w_latch;
    logic [DWELL_W-1:0]   w_dwell_eff;
    logic                 w_rev;
    logic [7:0]           w_wrap_col;
    logic                 w_row_end;
    logic                 w_last_cell;

    assign w_dwell_eff = (cfg_dwell == '0) ? c_one : cfg_dwell;

`ifdef SCAN_SERPENTINE_EN
    // The next row starts in the column where the previous row ended.
    assign w_rev      = r_row[0];
    assign w_wrap_col = r_col;
`else
    assign w_rev      = 1'b0;
    assign w_wrap_col = 8'd0;
`endif

    assign w_row_end   = w_rev ? (r_col == 8'd0) : (r_col == r_cols - 8'd1);
    assign w_last_cell = w_row_end && (r_row == r_rows - 8'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch   = 1'b1;
                    w_col_nxt = 8'd0;
                    w_row_nxt = 8'd0;
                    w_cnt_nxt = '0;
                    if (cfg_cols == 8'd0 || cfg_rows == 8'd0)
                        w_state_nxt = S_DONE;
                    else if (cfg_dwell <= c_one)
                        w_state_nxt = S_STEP;
                    else
                        w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                    if (r_cnt + c_one == r_dwell - c_one)
                        w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                w_cnt_nxt = '0;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_cell) begin
                    w_state_nxt = S_DONE;
                end else begin
                    if (w_row_end) begin
                        w_col_nxt = w_wrap_col;
                        w_row_nxt = r_row + 8'd1;
                    end else if (w_rev) begin
                        w_col_nxt = r_col - 8'd1;
                    end else begin
                        w_col_nxt = r_col + 8'd1;
                    end
                    w_state_nxt = (r_dwell == c_one) ? S_STEP : S_DWELL;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cols  <= 8'd0;
            r_rows  <= 8'd0;
            r_power <= 8'd0;
            r_dwell <= c_one;
            r_col   <= 8'd0;
            r_row   <= 8'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_cols  <= cfg_cols;
                r_rows  <= cfg_rows;
                r_power <= cfg_power;
                r_dwell <= w_dwell_eff;
            end
        end
    end

    assign cell_valid = (r_state == S_DWELL) || (r_state == S_STEP);
    assign busy       = cell_valid;
    assign done       = (r_state == S_DONE);
    assign column_o   = r_col;
    assign row_o      = r_row;
    assign power_o    = cell_valid ? r_power : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_la_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_scan_sequencer
// Purpose  : Self-checking bench for la_scan_sequencer against a cell-list
//            model of the scan (honours SCAN_SERPENTINE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_la_scan_sequencer;

    localparam int DW = 16;

    logic          wb_clk_i  = 1'b0;
    logic          wb_rst_i  = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [7:0]    cfg_cols  = 8'd0;
    logic [7:0]    cfg_rows  = 8'd0;
    logic [7:0]    cfg_power = 8'd0;
    logic [DW-1:0] cfg_dwell = '0;
    logic [7:0]    column_o;
    logic [7:0]    row_o;
    logic [7:0]    power_o;
    logic          cell_valid;
    logic          busy;
    logic          done;

    logic [26:0]   obs;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_col[$];
    int            exp_row[$];
    logic [7:0]    last_col = 8'd0;
    logic [7:0]    last_row = 8'd0;

    la_scan_sequencer #(.DWELL_W(DW)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start),
        .abort      (abort),
        .cfg_cols   (cfg_cols),
        .cfg_rows   (cfg_rows),
        .cfg_power  (cfg_power),
        .cfg_dwell  (cfg_dwell),
        .column_o   (column_o),
        .row_o      (row_o),
        .power_o    (power_o),
        .cell_valid (cell_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // {cell_valid, busy, done, column, row, power}
    assign obs = {cell_valid, busy, done, column_o, row_o, power_o};

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Expected cell for every active cycle of a scan, in visiting order.
    task automatic build_model(input int cols, input int rows, input int dwell);
        int d;
        int c;
        d = (dwell == 0) ? 1 : dwell;
        exp_col.delete();
        exp_row.delete();
        for (int r = 0; r < rows; r++) begin
            for (int i = 0; i < cols; i++) begin
                c = i;
`ifdef SCAN_SERPENTINE_EN
                if (r % 2 == 1) c = cols - 1 - i;
`endif
                for (int j = 0; j < d; j++) begin
                    exp_col.push_back(c);
                    exp_row.push_back(r);
                end
            end
        end
    endtask

    // Starts a scan on the current cycle and checks every cycle up to idle.
    // abort_at > 0 raises abort during that active cycle (1 = first cell cycle).
    task automatic do_scan(input string name, input int cols, input int rows,
                           input int dwell, input logic [7:0] pwr,
                           input int abort_at, input bit disturb);
        int          n;
        logic [26:0] e;
        logic [7:0]  ec;
        logic [7:0]  er;
        cfg_cols  = 8'(cols);
        cfg_rows  = 8'(rows);
        cfg_power = pwr;
        cfg_dwell = DW'(dwell);
        start     = 1'b1;
        build_model(cols, rows, dwell);
        n = exp_col.size();
        tick();
        start = 1'b0;
        if (n == 0) begin
            n_checks++;
            if ({obs[26:24], obs[7:0]} !== {3'b001, 8'h00}) begin
                n_fail++;
                $display("FAIL %s empty-done: got flags=%03b pwr=%02h, want flags=001 pwr=00",
                         name, obs[26:24], obs[7:0]);
            end
            tick();
            n_checks++;
            if ({obs[26:24], obs[7:0]} !== {3'b000, 8'h00}) begin
                n_fail++;
                $display("FAIL %s empty-idle: got flags=%03b pwr=%02h, want flags=000 pwr=00",
                         name, obs[26:24], obs[7:0]);
            end
            return;
        end
        for (int k = 0; k < n; k++) begin
            ec = 8'(exp_col[k]);
            er = 8'(exp_row[k]);
            e  = {3'b110, ec, er, pwr};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cell cycle %0d: got %07h, want %07h", name, k + 1, obs, e);
            end
            if (disturb) begin
                cfg_cols  = 8'($urandom);
                cfg_rows  = 8'($urandom);
                cfg_power = 8'($urandom);
                cfg_dwell = DW'($urandom);
                start     = 1'($urandom_range(0, 1));
            end
            if (k + 1 == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                e = {3'b000, ec, er, 8'h00};
                for (int j = 0; j < 5; j++) begin
                    n_checks++;
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL %s post-abort %0d: got %07h, want %07h", name, j, obs, e);
                    end
                    tick();
                end
                last_col = ec;
                last_row = er;
                return;
            end
            tick();
        end
        start = 1'b0;
        ec = 8'(exp_col[n-1]);
        er = 8'(exp_row[n-1]);
        e  = {3'b001, ec, er, 8'h00};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL %s done cycle %0d: got %07h, want %07h", name, n + 1, obs, e);
        end
        tick();
        e = {3'b000, ec, er, 8'h00};
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL %s idle after done: got %07h, want %07h", name, obs, e);
        end
        last_col = ec;
        last_row = er;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        tick();
        n_checks++;
        if (obs !== 27'h0) begin
            n_fail++;
            $display("FAIL reset state: got %07h, want 0000000", obs);
        end
        wb_rst_i = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tick();
        n_checks++;
        if (obs !== 27'h0) begin
            n_fail++;
            $display("FAIL reset release: got %07h, want 0000000", obs);
        end
    endtask

    task automatic test_basic();
        do_scan("basic_2x2", 2, 2, 3, 8'h04, 0, 1'b0);
        do_scan("dwell0_3x1", 3, 1, 0, 8'hA5, 0, 1'b0);
        do_scan("order_3x2", 3, 2, 1, 8'h5A, 0, 1'b0);
    endtask

    task automatic test_large();
        do_scan("large_17x17", 17, 17, 1, 8'h04, 0, 1'b0);
        do_scan("wide_255x2", 255, 2, 1, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_zero_counts();
        do_scan("zero_cols", 0, 5, 2, 8'h33, 0, 1'b0);
        do_scan("zero_rows", 4, 0, 1, 8'h33, 0, 1'b0);
    endtask

    task automatic test_abort();
        logic [26:0] e;
        do_scan("pre_abort", 2, 3, 1, 8'h10, 0, 1'b0);
        e = {3'b000, last_col, last_row, 8'h00};
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL idle_abort: got %07h, want %07h", obs, e);
        end
        do_scan("abort_3x3", 3, 3, 4, 8'h04, 6, 1'b0);
        do_scan("abort_on_step", 3, 3, 4, 8'h04, 8, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_scan("busy_start_cfg", 3, 3, 2, 8'h77, 0, 1'b1);
        do_scan("back_to_back", 2, 2, 1, 8'h01, 0, 1'b0);
    endtask

    task automatic test_reset_midscan();
        cfg_cols  = 8'd3;
        cfg_rows  = 8'd3;
        cfg_dwell = DW'(2);
        cfg_power = 8'h99;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wb_rst_i = 1'b1;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (obs !== 27'h0) begin
                n_fail++;
                $display("FAIL reset_midscan %0d: got %07h, want 0000000", j, obs);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int c;
        int r;
        int d;
        int n;
        int ab;
        for (int it = 0; it < 25; it++) begin
            c  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            r  = $urandom_range(1, 6);
            d  = $urandom_range(0, 3);
            n  = c * r * ((d == 0) ? 1 : d);
            ab = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            do_scan("random", c, r, d, 8'($urandom), ab, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large();
        test_zero_counts();
        test_abort();
        test_back_to_back();
        test_reset_midscan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
